// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller and the pipeline datapath.
// The slave side is the controller; the master side drives hazard inputs
// and consumes the register enables/flushes.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) ();
    logic [REG_W-1:0] id_src;
    logic [REG_W-1:0] id_dst;
    logic             id_src_used;
    logic             id_dst_used;
    logic [REG_W-1:0] ex_dst;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             cnt_clr;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_src, id_dst, id_src_used, id_dst_used, ex_dst, ex_mem_read,
               ex_branch_taken, mem_req, mem_ack, cnt_clr,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_flush, mem_timeout, stall_cnt
    );

    modport master (
        output id_src, id_dst, id_src_used, id_dst_used, ex_dst, ex_mem_read,
               ex_branch_taken, mem_req, mem_ack, cnt_clr,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_flush, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing controller for a 5-stage pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle data-memory freezes with a watchdog.
// Enables/flushes are combinational from state and inputs; a saturating
// counter tracks cycles in which the PC is held.
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 3,
    parameter int TMO_MAX = 255,
    parameter int CNT_W   = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [1:0]  S_INIT  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_WAIT  = 2'd2;
    localparam logic [1:0]  S_HALT  = 2'd3;
    localparam logic [15:0] TMO_LIM = 16'(TMO_MAX);

    logic [1:0]       state_q, state_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_W-1:0] id_src, id_dst, ex_dst;
    logic             load_use;
    logic             apply_rules;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, memwb_flush;

    assign id_src = bus.id_src;
    assign id_dst = bus.id_dst;
    assign ex_dst = bus.ex_dst;

    // A load in EX whose destination is an operand of the ID instruction.
    assign load_use = bus.ex_mem_read &
                      ((bus.id_src_used & (id_src == ex_dst)) |
                       (bus.id_dst_used & (id_dst == ex_dst)));

    // Next-state, watchdog and pipeline-control decode.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_d       = tmo_q;
        apply_rules = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        case (state_q)
            S_INIT: begin
                {pc_en, ifid_en, idex_en, exmem_en}     = 4'b0000;
                {ifid_flush, idex_flush, memwb_flush}   = 3'b111;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_flush = 1'b1;
                    tmo_cnt_d   = 16'd1;
                    state_d     = S_WAIT;
                end else begin
                    apply_rules = 1'b1;
                end
            end
            S_WAIT: begin
                if (!bus.mem_ack) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_flush = 1'b1;
                    tmo_cnt_d   = tmo_cnt_q + 16'd1;
                    if (tmo_cnt_q == TMO_LIM) begin
                        tmo_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end else begin
                    // Branch/load-use inputs held during the wait resolve now.
                    apply_rules = 1'b1;
                    state_d     = S_RUN;
                end
            end
            default: begin
                {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                memwb_flush = 1'b1;
            end
        endcase
        if (apply_rules) begin
            if (bus.ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    // Stall counter: saturating, clear wins, reset cycle not counted.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != S_INIT) && !pc_en && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
        if (bus.cnt_clr)
            cnt_d = '0;
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_flush = memwb_flush;
    assign bus.mem_timeout = tmo_q;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl with a
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Output vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush
    localparam logic [6:0] V_INIT   = 7'b0010101;
    localparam logic [6:0] V_FREEZE = 7'b0000001;
    localparam logic [6:0] V_BRANCH = 7'b1111110;
    localparam logic [6:0] V_LU     = 7'b0001110;
    localparam logic [6:0] V_RUN    = 7'b1101010;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;

    // Model: fresh-after-reset, waiting on memory, halted, wait cycle number, stall count, timeout flag
    bit m_init, m_wait, m_halt, m_tmo;
    int m_wn, m_cnt;

    pipeline_hazard_ctrl_if #(.REG_W(3), .CNT_W(CW)) hif ();

    pipeline_hazard_ctrl #(.REG_W(3), .TMO_MAX(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
                hif.idex_flush, hif.exmem_en, hif.memwb_flush};
    endfunction

    function automatic logic [6:0] exp_out();
        bit lu, frz;
        if (!rst_n || m_init) return V_INIT;
        if (m_halt) return V_FREEZE;
        frz = m_wait ? !hif.mem_ack : (hif.mem_req && !hif.mem_ack);
        if (frz) return V_FREEZE;
        if (hif.ex_branch_taken) return V_BRANCH;
        lu = hif.ex_mem_read &&
             ((hif.id_src_used && hif.id_src == hif.ex_dst) ||
              (hif.id_dst_used && hif.id_dst == hif.ex_dst));
        if (lu) return V_LU;
        return V_RUN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] s, input logic [2:0] d, input logic [2:0] xd,
                          input logic su, input logic du, input logic mr, input logic br,
                          input logic rq, input logic ak, input logic cc);
        hif.id_src = s;  hif.id_dst = d;  hif.ex_dst = xd;
        hif.id_src_used = su;  hif.id_dst_used = du;  hif.ex_mem_read = mr;
        hif.ex_branch_taken = br;  hif.mem_req = rq;  hif.mem_ack = ak;  hif.cnt_clr = cc;
    endtask

    task automatic idle(input logic cc);
        set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cc);
    endtask

    // Called at posedge+1 with inputs already applied: check outputs, clock, update model, check registers.
    task automatic step();
        logic [6:0] e;
        #1;
        e = exp_out();
        chk("ctrl_outs", 32'(outs()), 32'(e));
        @(posedge clk);
        if (!m_init && !e[6]) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
        if (hif.cnt_clr) m_cnt = 0;
        if (m_init) m_init = 0;
        else if (m_halt) m_halt = 1;
        else if (m_wait) begin
            if (hif.mem_ack) m_wait = 0;
            else if (m_wn == TMO) begin m_wait = 0; m_halt = 1; m_tmo = 1; end
            else m_wn++;
        end else if (hif.mem_req && !hif.mem_ack) begin
            m_wait = 1; m_wn = 1;
        end
        #1;
        chk("stall_cnt", 32'(hif.stall_cnt), 32'(m_cnt));
        chk("mem_timeout", 32'(hif.mem_timeout), 32'(m_tmo));
    endtask

    // Assert reset at posedge+1, check immediate effect, release one edge later.
    task automatic do_reset();
        rst_n = 1'b0;
        m_init = 1; m_wait = 0; m_halt = 0; m_tmo = 0; m_wn = 0; m_cnt = 0;
        #1;
        chk("rst_outs", 32'(outs()), 32'(V_INIT));
        chk("rst_cnt", 32'(hif.stall_cnt), 32'd0);
        chk("rst_tmo", 32'(hif.mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        @(posedge clk);
        #1;
        do_reset();
        idle(1'b0); step();               // INIT cycle
        idle(1'b0); step();               // RUN

        // Load-use: one bubble, counted once
        idle(1'b1); step();
        set_in(3'd3, 3'd5, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk("lu_outs", 32'(outs()), 32'(V_LU)); step();
        chk("lu_cnt", 32'(hif.stall_cnt), 32'd1);
        idle(1'b0);
        #1; chk("lu_release", 32'(outs()), 32'(V_RUN)); step();

        // Branch beats load-use
        set_in(3'd3, 3'd5, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; chk("br_outs", 32'(outs()), 32'(V_BRANCH)); step();
        chk("br_cnt", 32'(hif.stall_cnt), 32'd1);

        // Memory wait, ack on 4th cycle
        idle(1'b1); step();
        for (int i = 0; i < 3; i++) begin
            set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1; chk("mw_freeze", 32'(outs()), 32'(V_FREEZE)); step();
        end
        set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1; chk("mw_ack", 32'(outs()), 32'(V_RUN)); step();
        idle(1'b0); step();
        chk("mw_cnt", 32'(hif.stall_cnt), 32'd3);

        // Timeout after 4 wait cycles, HALT is sticky
        for (int i = 0; i < 4; i++) begin
            set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("tmo_pre", 32'(hif.mem_timeout), 32'd0);
        step();
        chk("tmo_set", 32'(hif.mem_timeout), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            #1; chk("halt_outs", 32'(outs()), 32'(V_FREEZE)); step();
        end
        chk("halt_tmo", 32'(hif.mem_timeout), 32'd1);

        // Reset during MEM_WAIT
        do_reset();
        idle(1'b0); step(); step();
        set_in(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); step();
        do_reset();
        idle(1'b0);
        #1; chk("post_rst_init", 32'(outs()), 32'(V_INIT)); step();
        #1; chk("post_rst_run", 32'(outs()), 32'(V_RUN)); step();
        chk("post_rst_cnt", 32'(hif.stall_cnt), 32'd0);

        // Saturation and clear-beats-increment
        set_in(3'd1, 3'd6, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", 32'(hif.stall_cnt), 32'd15);
        hif.cnt_clr = 1'b1;
        step();
        chk("clr_cnt", 32'(hif.stall_cnt), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            set_in(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom_range(0, 19) == 0));
            if ((m_halt && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0)
                do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
